gs_cfg_seq: RTL and testbench



---
 rtl/gs_pkg.sv | 21 ++
 rtl/sync2.sv | 25 ++
 rtl/gs_cfg_seq.sv | 141 ++++++++++++++
 tb/tb_gs_cfg_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared definitions for the GS board FPGA configuration sequencer.
package gs_pkg;

   // Sequencer state encoding, also exported on the Z80 status port
   typedef enum logic [2:0] {
      ST_CFGLOW  = 3'd0,
      ST_WSTAT   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_INIT    = 3'd3,
      ST_WARMRST = 3'd4,
      ST_RUN     = 3'd5,
      ST_RETRY   = 3'd6,
      ST_FAIL    = 3'd7
   } cfg_state_e;

   localparam int unsigned CFG_LOW_CYC_DEF = 64;
   localparam int unsigned TMO_W_DEF       = 22;
   localparam int unsigned RST_CYC_DEF     = 15;
   localparam int unsigned MAX_RETRY_DEF   = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous pad inputs.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Double-register the pad to settle metastability
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/gs_cfg_seq.sv
// ACEX1K configuration / warm-reset sequencer with retry and watchdog.
module gs_cfg_seq
   import gs_pkg::*;
#(
   parameter int unsigned CFG_LOW_CYC = CFG_LOW_CYC_DEF,
   parameter int unsigned TMO_W       = TMO_W_DEF,
   parameter int unsigned RST_CYC     = RST_CYC_DEF,
   parameter int unsigned MAX_RETRY   = MAX_RETRY_DEF
) (
   input  logic       clkin,
   input  logic       coldres_n,
   input  logic       status_n,
   input  logic       conf_done,
   input  logic       init_done,
   input  logic       reconf_req,
   input  logic       clr_cold,
   output logic       config_n,
   output logic       cs,
   output logic       warmres_n,
   output logic [2:0] cfg_state,
   output logic       cfg_err,
   output logic       cold_flag
);

   localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
   localparam logic [TMO_W-1:0] CFG_LAST = TMO_W'(CFG_LOW_CYC - 1);
   localparam logic [TMO_W-1:0] RST_LAST = TMO_W'(RST_CYC - 1);
   // Wait states last 2^TMO_W-1 cycles before the watchdog fires
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((64'd1 << TMO_W) - 64'd2);
   localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

   logic s_status_n, s_conf_done, s_init_done;

   cfg_state_e       state_q, state_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic             stat_prev_q, stat_prev_d;
   logic             config_n_q, config_n_d;
   logic             cs_q, cs_d;
   logic             warmres_n_q, warmres_n_d;
   logic             cfg_err_q, cfg_err_d;
   logic             cold_flag_q, cold_flag_d;
   logic             tmo;

   sync2 u_sync_status (.clk(clkin), .rst_n(coldres_n), .d(status_n),  .q(s_status_n));
   sync2 u_sync_conf   (.clk(clkin), .rst_n(coldres_n), .d(conf_done), .q(s_conf_done));
   sync2 u_sync_init   (.clk(clkin), .rst_n(coldres_n), .d(init_done), .q(s_init_done));

   assign tmo = (cnt_q == TMO_LAST);

   // Next-state, counters and registered output values
   always_comb begin
      state_d     = state_q;
      retry_d     = retry_q;
      cnt_d       = cnt_q;
      stat_prev_d = s_status_n;
      cfg_err_d   = cfg_err_q;
      cold_flag_d = clr_cold ? 1'b0 : cold_flag_q;

      // Later assignments win: watchdog first, then the state's own progress
      case (state_q)
         ST_CFGLOW:  if (cnt_q == CFG_LAST) state_d = ST_WSTAT;
         ST_WSTAT: begin
            if (tmo)        state_d = ST_RETRY;
            if (s_status_n) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (tmo || !s_status_n) state_d = ST_RETRY;
            if (s_conf_done)        state_d = ST_INIT;
         end
         ST_INIT: begin
            if (tmo)         state_d = ST_RETRY;
            if (s_init_done) state_d = ST_WARMRST;
         end
         ST_WARMRST: if (cnt_q == RST_LAST) state_d = ST_RUN;
         ST_RUN: begin
            retry_d = '0;
            if (stat_prev_q && !s_status_n) state_d = ST_RETRY;
            if (reconf_req)                 state_d = ST_CFGLOW;
         end
         ST_RETRY: begin
            retry_d = retry_q + RTY_W'(1);
            state_d = (retry_q >= RTY_LAST) ? ST_FAIL : ST_CFGLOW;
         end
         ST_FAIL: begin
            if (reconf_req) begin
               retry_d = '0;
               state_d = ST_CFGLOW;
            end
         end
         default: state_d = ST_CFGLOW;
      endcase

      // Shared timer: cleared on every state change, runs only in timed states
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q inside {ST_CFGLOW, ST_WSTAT, ST_LOAD, ST_INIT, ST_WARMRST}) begin
         cnt_d = cnt_q + TMO_W'(1);
      end

      if (state_d == ST_RETRY)    cfg_err_d = 1'b1;
      else if (state_d == ST_RUN) cfg_err_d = 1'b0;

      config_n_d  = (state_d != ST_CFGLOW);
      cs_d        = (state_d == ST_WARMRST) || (state_d == ST_RUN);
      warmres_n_d = !((state_d == ST_CFGLOW) || (state_d == ST_WARMRST));
   end

   // State, counters and output registers
   always_ff @(posedge clkin or negedge coldres_n) begin
      if (!coldres_n) begin
         state_q     <= ST_CFGLOW;
         cnt_q       <= '0;
         retry_q     <= '0;
         stat_prev_q <= 1'b0;
         config_n_q  <= 1'b0;
         cs_q        <= 1'b0;
         warmres_n_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         cold_flag_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         stat_prev_q <= stat_prev_d;
         config_n_q  <= config_n_d;
         cs_q        <= cs_d;
         warmres_n_q <= warmres_n_d;
         cfg_err_q   <= cfg_err_d;
         cold_flag_q <= cold_flag_d;
      end
   end

   assign config_n  = config_n_q;
   assign cs        = cs_q;
   assign warmres_n = warmres_n_q;
   assign cfg_state = state_q;
   assign cfg_err   = cfg_err_q;
   assign cold_flag = cold_flag_q;

endmodule

// File: tb/tb_gs_cfg_seq.sv
// Directed self-checking bench for gs_cfg_seq.
module tb_gs_cfg_seq;
   import gs_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (default parameters)
   logic coldres_n, status_n, conf_done, init_done, reconf_req, clr_cold;
   logic config_n, cs, warmres_n, cfg_err, cold_flag;
   logic [2:0] cfg_state;

   // Short-watchdog instance
   logic t_rst_n, t_status_n, t_conf_done, t_init_done, t_reconf_req, t_clr_cold;
   logic t_config_n, t_cs, t_warmres_n, t_cfg_err, t_cold_flag;
   logic [2:0] t_cfg_state;

   int errors = 0;
   int checks = 0;
   bit ok;

   gs_cfg_seq dut (
      .clkin(clk), .coldres_n(coldres_n), .status_n(status_n), .conf_done(conf_done),
      .init_done(init_done), .reconf_req(reconf_req), .clr_cold(clr_cold),
      .config_n(config_n), .cs(cs), .warmres_n(warmres_n), .cfg_state(cfg_state),
      .cfg_err(cfg_err), .cold_flag(cold_flag)
   );

   gs_cfg_seq #(.TMO_W(6)) dut_t (
      .clkin(clk), .coldres_n(t_rst_n), .status_n(t_status_n), .conf_done(t_conf_done),
      .init_done(t_init_done), .reconf_req(t_reconf_req), .clr_cold(t_clr_cold),
      .config_n(t_config_n), .cs(t_cs), .warmres_n(t_warmres_n), .cfg_state(t_cfg_state),
      .cfg_err(t_cfg_err), .cold_flag(t_cold_flag)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_state(input logic [2:0] st, input int lim, output bit found);
      found = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(posedge clk);
         #1;
         if (cfg_state == st) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      coldres_n = 1'b1; status_n = 1'b0; conf_done = 1'b0; init_done = 1'b0;
      reconf_req = 1'b0; clr_cold = 1'b0;
      t_rst_n = 1'b1; t_status_n = 1'b0; t_conf_done = 1'b0; t_init_done = 1'b0;
      t_reconf_req = 1'b0; t_clr_cold = 1'b0;
      #2;
      coldres_n = 1'b0;
      t_rst_n   = 1'b0;
      #1;
      checks++; if (config_n !== 1'b0)  begin errors++; $display("FAIL reset_config_n got=%b exp=0", config_n); end
      checks++; if (cs !== 1'b0)        begin errors++; $display("FAIL reset_cs got=%b exp=0", cs); end
      checks++; if (warmres_n !== 1'b0) begin errors++; $display("FAIL reset_warmres_n got=%b exp=0", warmres_n); end
      checks++; if (cfg_err !== 1'b0)   begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
      checks++; if (cold_flag !== 1'b1) begin errors++; $display("FAIL reset_cold_flag got=%b exp=1", cold_flag); end
      checks++; if (cfg_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", cfg_state); end
      tick(2);
      coldres_n = 1'b1;
   endtask

   // Edge n is the n-th rising clock after reset release
   task automatic test_normal_load;
      int warm_low = 0;
      bit cs_bad = 1'b0;
      for (int n = 1; n <= 560; n++) begin
         tick(1);
         if (n >= 100 && warmres_n == 1'b0) begin
            warm_low++;
            if (cs !== 1'b1) cs_bad = 1'b1;
         end
         if (n == 63) begin
            checks++; if (config_n !== 1'b0) begin errors++; $display("FAIL load_cfgn_63 got=%b exp=0", config_n); end
         end
         if (n == 64) begin
            checks++; if (config_n !== 1'b1) begin errors++; $display("FAIL load_cfgn_64 got=%b exp=1", config_n); end
            checks++; if (cfg_state !== 3'd1) begin errors++; $display("FAIL load_wstat got=%0d exp=1", cfg_state); end
         end
         if (n == 65) begin
            checks++; if (cfg_state !== 3'd2) begin errors++; $display("FAIL load_load got=%0d exp=2", cfg_state); end
         end
         if (n == 502) begin
            checks++; if (cfg_state !== 3'd2) begin errors++; $display("FAIL load_sync_lat got=%0d exp=2", cfg_state); end
         end
         if (n == 503) begin
            checks++; if (cfg_state !== 3'd3) begin errors++; $display("FAIL load_init got=%0d exp=3", cfg_state); end
         end
         if (n == 522) begin
            checks++; if ({cs, warmres_n} !== 2'b01) begin errors++; $display("FAIL load_pre_warm got=%b exp=01", {cs, warmres_n}); end
         end
         if (n == 523) begin
            checks++; if ({cs, warmres_n} !== 2'b10) begin errors++; $display("FAIL load_warm_start got=%b exp=10", {cs, warmres_n}); end
            checks++; if (cfg_state !== 3'd4) begin errors++; $display("FAIL load_warmrst got=%0d exp=4", cfg_state); end
         end
         if (n == 538) begin
            checks++; if ({cs, warmres_n} !== 2'b11) begin errors++; $display("FAIL load_run_out got=%b exp=11", {cs, warmres_n}); end
            checks++; if (cfg_state !== 3'd5) begin errors++; $display("FAIL load_run got=%0d exp=5", cfg_state); end
            checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL load_cfg_err got=%b exp=0", cfg_err); end
         end
         if (n == 10)  status_n  = 1'b1;
         if (n == 500) conf_done = 1'b1;
         if (n == 520) init_done = 1'b1;
      end
      checks++; if (warm_low != 15) begin errors++; $display("FAIL load_warm_width got=%0d exp=15", warm_low); end
      checks++; if (cs_bad !== 1'b0) begin errors++; $display("FAIL load_cs_during_warm got=%b exp=0", cs_bad); end
   endtask

   task automatic test_cold_clear;
      clr_cold = 1'b1;
      tick(1);
      clr_cold = 1'b0;
      checks++; if (cold_flag !== 1'b0) begin errors++; $display("FAIL cold_clear got=%b exp=0", cold_flag); end
   endtask

   task automatic test_reconf_run;
      reconf_req = 1'b1; status_n = 1'b0; conf_done = 1'b0; init_done = 1'b0;
      tick(1);
      reconf_req = 1'b0;
      checks++; if ({config_n, cs} !== 2'b00) begin errors++; $display("FAIL reconf_run_out got=%b exp=00", {config_n, cs}); end
      checks++; if (cfg_state !== 3'd0) begin errors++; $display("FAIL reconf_run_state got=%0d exp=0", cfg_state); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reconf_run_err got=%b exp=0", cfg_err); end
   endtask

   task automatic test_load_error;
      tick(5);
      status_n = 1'b1;
      for (int a = 0; a < 3; a++) begin
         wait_state(ST_LOAD, 300, ok);
         checks++; if (!ok) begin errors++; $display("FAIL lderr_reach_load got=timeout exp=state2 attempt=%0d", a); end
         status_n = 1'b0;
         tick(2);
         status_n = 1'b1;
         wait_state(ST_RETRY, 10, ok);
         checks++; if (!ok) begin errors++; $display("FAIL lderr_reach_retry got=timeout exp=state6 attempt=%0d", a); end
         checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL lderr_cfg_err got=%b exp=1", cfg_err); end
         tick(1);
         if (a < 2) begin
            checks++; if ({cfg_state, config_n} !== {3'd0, 1'b0}) begin errors++; $display("FAIL lderr_restart got=%0d/%b exp=0/0", cfg_state, config_n); end
         end else begin
            checks++; if (cfg_state !== 3'd7) begin errors++; $display("FAIL lderr_fail_state got=%0d exp=7", cfg_state); end
            checks++; if ({config_n, cs, warmres_n} !== 3'b101) begin errors++; $display("FAIL lderr_fail_out got=%b exp=101", {config_n, cs, warmres_n}); end
         end
      end
   endtask

   task automatic test_reconf_fail;
      tick(3);
      checks++; if (cfg_state !== 3'd7) begin errors++; $display("FAIL rfail_stays got=%0d exp=7", cfg_state); end
      reconf_req = 1'b1;
      tick(1);
      reconf_req = 1'b0;
      checks++; if ({cfg_state, config_n} !== {3'd0, 1'b0}) begin errors++; $display("FAIL rfail_restart got=%0d/%b exp=0/0", cfg_state, config_n); end
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rfail_err_sticky got=%b exp=1", cfg_err); end
      // one failed attempt must restart, not fail, since the retry count was cleared
      wait_state(ST_LOAD, 300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rfail_reach_load got=timeout exp=state2"); end
      status_n = 1'b0;
      tick(2);
      status_n = 1'b1;
      wait_state(ST_RETRY, 10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rfail_reach_retry got=timeout exp=state6"); end
      tick(1);
      checks++; if (cfg_state !== 3'd0) begin errors++; $display("FAIL rfail_retry_cleared got=%0d exp=0", cfg_state); end
      conf_done = 1'b1;
      init_done = 1'b1;
      wait_state(ST_RUN, 300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rfail_reach_run got=timeout exp=state5"); end
      checks++; if ({cfg_err, cs, warmres_n} !== 3'b011) begin errors++; $display("FAIL rfail_run_out got=%b exp=011", {cfg_err, cs, warmres_n}); end
   endtask

   task automatic test_reset_mid_load;
      reconf_req = 1'b1; status_n = 1'b0; conf_done = 1'b0; init_done = 1'b0;
      tick(1);
      reconf_req = 1'b0;
      tick(4);
      status_n = 1'b1;
      wait_state(ST_LOAD, 300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mid_reach_load got=timeout exp=state2"); end
      reconf_req = 1'b1;
      tick(1);
      reconf_req = 1'b0;
      tick(2);
      checks++; if ({cfg_state, config_n} !== {3'd2, 1'b1}) begin errors++; $display("FAIL mid_reconf_ignored got=%0d/%b exp=2/1", cfg_state, config_n); end
      #2;
      coldres_n = 1'b0;
      #1;
      checks++; if ({config_n, cs, warmres_n} !== 3'b000) begin errors++; $display("FAIL mid_async_out got=%b exp=000", {config_n, cs, warmres_n}); end
      checks++; if (cold_flag !== 1'b1) begin errors++; $display("FAIL mid_cold_flag got=%b exp=1", cold_flag); end
      checks++; if (cfg_state !== 3'd0) begin errors++; $display("FAIL mid_state got=%0d exp=0", cfg_state); end
   endtask

   task automatic test_clr_with_reset;
      @(posedge clk);
      #1;
      clr_cold = 1'b1;
      tick(1);
      clr_cold = 1'b0;
      tick(1);
      checks++; if (cold_flag !== 1'b1) begin errors++; $display("FAIL clr_vs_reset got=%b exp=1", cold_flag); end
      coldres_n = 1'b1;
   endtask

   task automatic test_timeout;
      t_status_n = 1'b1;
      t_rst_n    = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         tick(1);
         if (n == 65) begin
            checks++; if (t_cfg_state !== 3'd2) begin errors++; $display("FAIL tmo_load got=%0d exp=2", t_cfg_state); end
         end
         if (n == 127) begin
            checks++; if (t_cfg_state !== 3'd2) begin errors++; $display("FAIL tmo_early got=%0d exp=2", t_cfg_state); end
         end
         if (n == 128) begin
            checks++; if (t_cfg_state !== 3'd6) begin errors++; $display("FAIL tmo_retry got=%0d exp=6", t_cfg_state); end
         end
         if (n == 129) begin
            checks++; if ({t_cfg_state, t_config_n} !== {3'd0, 1'b0}) begin errors++; $display("FAIL tmo_restart got=%0d/%b exp=0/0", t_cfg_state, t_config_n); end
            checks++; if ({t_cfg_err, t_cs, t_warmres_n, t_cold_flag} !== 4'b1001) begin errors++; $display("FAIL tmo_flags got=%b exp=1001", {t_cfg_err, t_cs, t_warmres_n, t_cold_flag}); end
         end
         if (n == 192) begin
            checks++; if (t_config_n !== 1'b0) begin errors++; $display("FAIL tmo_cfgn_192 got=%b exp=0", t_config_n); end
         end
         if (n == 193) begin
            checks++; if (t_config_n !== 1'b1) begin errors++; $display("FAIL tmo_cfgn_193 got=%b exp=1", t_config_n); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_normal_load;
      test_cold_clear;
      test_reconf_run;
      test_load_error;
      test_reconf_fail;
      test_reset_mid_load;
      test_clr_with_reset;
      test_timeout;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=stuck exp=finish");
      $fatal(1, "simulation time limit");
   end

endmodule
